fetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end for the 3-stage RV32 core; replaces the PC register and
//  the stall-holding instruction latch with one block. Drives the synchronous icache, keeps a DEPTH-entry

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_queue.sv | 113 +++++++++++
 tb/tb_fetch_queue.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pkg
// Brief   : Shared constants and the queue entry type for the fetch front end.
// Revision: 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam logic [31:0] c_reset_pc       = 32'h0000_2000;
   localparam logic [6:0]  c_opcode_op_imm  = 7'b001_0011;
   // addi x0, x0, 0
   localparam logic [31:0] c_nop            = {12'd0, 5'd0, 3'b000, 5'd0, c_opcode_op_imm};

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fetch_fifo
// Brief   : Synchronous FIFO with flush; flush dominates enqueue and dequeue.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enq,
   input  logic [WIDTH-1:0]         enq_data,
   input  logic                     deq,
   input  logic                     flush,
   output logic [WIDTH-1:0]         deq_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int c_aw = $clog2(DEPTH);

   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_aw:0]    r_count;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic w_full;
   logic w_empty;
   logic w_do_enq;
   logic w_do_deq;

   assign w_full   = (r_count == (c_aw+1)'(DEPTH));
   assign w_empty  = (r_count == '0);
   assign w_do_deq = deq & ~w_empty;
   // A full queue still accepts when the head leaves at the same edge.
   assign w_do_enq = enq & (~w_full | w_do_deq);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_enq) r_wr_ptr <= r_wr_ptr + c_aw'(1);
         if (w_do_deq) r_rd_ptr <= r_rd_ptr + c_aw'(1);
         case ({w_do_enq, w_do_deq})
            2'b10:   r_count <= r_count + (c_aw+1)'(1);
            2'b01:   r_count <= r_count - (c_aw+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_enq && !flush && !reset) r_mem[r_wr_ptr] <= enq_data;
   end

   assign deq_data = r_mem[r_rd_ptr];
   assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue
// Brief   : Instruction fetch front end: PC, icache request/response, prefetch queue.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = c_reset_pc,
   parameter logic [31:0] NOP      = c_nop
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic [31:0]              icache_addr,
   output logic                     icache_re,
   input  logic [31:0]              icache_dout,
   input  logic                     stall,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_instr,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int c_cw = $clog2(DEPTH) + 1;

   logic [31:0]      r_fetch_pc;
   logic [31:0]      r_inflight_pc;
   logic             r_inflight_v;
   logic             r_inflight_epoch;
   logic             r_epoch;

   logic [31:0]      w_addr;
   logic [c_cw-1:0]  w_count;
   logic [c_cw-1:0]  w_pending;
   logic             w_has_room;
   logic             w_accept;
   logic             w_redirect_take;
   logic             w_epoch_next;
   logic             w_resp;
   logic             w_enq;
   logic             w_deq;
   logic             w_out_valid;
   fetch_entry_t     w_enq_entry;
   fetch_entry_t     w_head;
   logic [63:0]      w_head_bits;

   assign w_addr     = (redirect ? redirect_pc : r_fetch_pc) & 32'hFFFF_FFFC;
   // Reserve a queue slot for the outstanding request so its response always fits.
   assign w_pending  = w_count + c_cw'(r_inflight_v);
   assign w_has_room = (w_pending < c_cw'(DEPTH));

   assign icache_addr = w_addr;
   assign icache_re   = ~reset & (w_has_room | redirect);

   assign w_accept        = icache_re & ~stall;
   assign w_redirect_take = redirect & ~stall;
   assign w_epoch_next    = r_epoch ^ w_redirect_take;

   // Stale responses are those issued before a redirect: wrong epoch or killed this cycle.
   assign w_resp = r_inflight_v & ~stall;
   assign w_enq  = w_resp & ~redirect & (r_inflight_epoch == r_epoch);

   assign w_out_valid = ~reset & (w_count != '0);
   assign w_deq       = w_out_valid & out_ready & ~stall & ~redirect;

   assign w_enq_entry = '{pc: r_inflight_pc, instr: icache_dout};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc       <= RESET_PC;
         r_inflight_pc    <= RESET_PC;
         r_inflight_v     <= 1'b0;
         r_inflight_epoch <= 1'b0;
         r_epoch          <= 1'b0;
      end else if (!stall) begin
         r_epoch      <= w_epoch_next;
         r_inflight_v <= w_accept;
         if (w_accept) begin
            r_fetch_pc       <= w_addr + 32'd4;
            r_inflight_pc    <= w_addr;
            r_inflight_epoch <= w_epoch_next;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .enq      (w_enq),
      .enq_data (w_enq_entry),
      .deq      (w_deq),
      .flush    (w_redirect_take),
      .deq_data (w_head_bits),
      .count    (w_count)
   );

   assign w_head = fetch_entry_t'(w_head_bits);

   assign out_valid = w_out_valid;
   assign out_pc    = reset ? RESET_PC : w_head.pc;
   assign out_instr = w_out_valid ? w_head.instr : NOP;
   assign occupancy = reset ? '0 : w_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_queue
// Brief   : Directed self-checking bench for fetch_queue with a one-cycle icache model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

   logic        clk;
   logic        reset;
   logic [31:0] icache_addr;
   logic        icache_re;
   logic [31:0] icache_dout;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [2:0]  occupancy;

   int n_vec;
   int n_err;

   fetch_queue #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_2000),
      .NOP      (32'h0000_0013)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .icache_addr (icache_addr),
      .icache_re   (icache_re),
      .icache_dout (icache_dout),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_instr   (out_instr),
      .occupancy   (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Synchronous icache: data for an accepted request appears the next cycle and holds.
   always @(posedge clk) begin
      if (icache_re && !stall) icache_dout <= imem(icache_addr);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) advance();
      reset = 1'b0;
   endtask

   task automatic chk_head(input string tag, input logic [31:0] pc);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_pc"}, out_pc, pc);
      chk({tag, "_instr"}, out_instr, imem(pc));
   endtask

   logic [31:0] e;

   initial begin
      n_vec = 0;
      n_err = 0;
      icache_dout = 32'hDEAD_BEEF;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = 32'd0;
      out_ready = 1'b1;

      // Reset state
      reset = 1'b1;
      repeat (3) advance();
      sample();
      chk("rst_re", 32'(icache_re), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_occ", 32'(occupancy), 32'd0);
      chk("rst_instr", out_instr, 32'h0000_0013);
      chk("rst_pc", out_pc, 32'h0000_2000);
      advance();
      reset = 1'b0;

      // 1: linear stream, first output two cycles after release
      for (int k = 0; k < 10; k++) begin
         sample();
         e = 32'h2000 + 32'(4 * k);
         chk("t1_addr", icache_addr, e);
         if (k >= 2) chk_head("t1", e - 32'd8);
         else begin
            chk("t1_empty_valid", 32'(out_valid), 32'd0);
            chk("t1_empty_instr", out_instr, 32'h0000_0013);
         end
         advance();
      end

      // 2: backpressure fills exactly DEPTH entries, then drains in order
      out_ready = 1'b0;
      do_reset(2);
      repeat (8) advance();
      sample();
      chk("t2_occ", 32'(occupancy), 32'd4);
      chk("t2_re", 32'(icache_re), 32'd0);
      chk("t2_addr", icache_addr, 32'h2010);
      chk_head("t2_full", 32'h2000);
      advance();
      out_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         sample();
         chk_head("t2_drain", 32'h2000 + 32'(4 * j));
         advance();
      end

      // 3: redirect while three entries are queued
      out_ready = 1'b0;
      do_reset(1);
      repeat (4) advance();
      redirect = 1'b1;
      redirect_pc = 32'h3000;
      sample();
      chk("t3_occ_pre", 32'(occupancy), 32'd3);
      chk("t3_addr", icache_addr, 32'h3000);
      chk("t3_re", 32'(icache_re), 32'd1);
      advance();
      redirect = 1'b0;
      out_ready = 1'b1;
      sample();
      chk("t3_occ_post", 32'(occupancy), 32'd0);
      chk("t3_valid_post", 32'(out_valid), 32'd0);
      chk("t3_instr_post", out_instr, 32'h0000_0013);
      advance();
      sample();
      chk_head("t3_target", 32'h3000);
      advance();
      sample();
      chk_head("t3_next", 32'h3004);
      advance();

      // 4: five-cycle stall freezes everything, then the stream resumes
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sample();
         chk_head("t4_stall", 32'h3008);
         chk("t4_addr", icache_addr, 32'h3010);
         chk("t4_occ", 32'(occupancy), 32'd1);
         advance();
      end
      stall = 1'b0;
      for (int j = 0; j < 4; j++) begin
         sample();
         chk_head("t4_resume", 32'h3008 + 32'(4 * j));
         advance();
      end

      // 5: redirect with a response landing the same cycle and decode ready
      redirect = 1'b1;
      redirect_pc = 32'h4003;
      sample();
      chk("t5_addr", icache_addr, 32'h4000);
      chk_head("t5_old_head", 32'h3018);
      advance();
      redirect = 1'b0;
      sample();
      chk("t5_occ", 32'(occupancy), 32'd0);
      chk("t5_valid", 32'(out_valid), 32'd0);
      advance();
      sample();
      chk_head("t5_target", 32'h4000);
      chk("t5_occ_one", 32'(occupancy), 32'd1);
      advance();
      sample();
      chk_head("t5_next", 32'h4004);
      advance();

      // 5b: pc + 4 wraps at 2^32
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      advance();
      redirect = 1'b0;
      advance();
      sample();
      chk_head("t5_wrap_hi", 32'hFFFF_FFFC);
      advance();
      sample();
      chk_head("t5_wrap_lo", 32'h0000_0000);
      advance();

      // 6: reset while full with a request in flight
      out_ready = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h5000;
      advance();
      redirect = 1'b0;
      repeat (3) advance();
      sample();
      chk("t6_occ_full", 32'(occupancy), 32'd3);
      chk("t6_re_full", 32'(icache_re), 32'd0);
      reset = 1'b1;
      #1;
      chk("t6_rst_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_occ", 32'(occupancy), 32'd0);
      chk("t6_rst_instr", out_instr, 32'h0000_0013);
      advance();
      reset = 1'b0;
      out_ready = 1'b1;
      sample();
      chk("t6_valid", 32'(out_valid), 32'd0);
      chk("t6_occ", 32'(occupancy), 32'd0);
      chk("t6_addr", icache_addr, 32'h2000);
      advance();
      sample();
      chk("t6_c1_instr", out_instr, 32'h0000_0013);
      chk("t6_c1_valid", 32'(out_valid), 32'd0);
      advance();
      sample();
      chk_head("t6_first", 32'h2000);
      advance();
      sample();
      chk_head("t6_second", 32'h2004);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
